// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM domain arbiter.
// Optional flush slot is controlled by the TDM_FLUSH_EN macro.
package tdm_pkg;

  typedef enum logic {
    DOM_L = 1'b0,
    DOM_H = 1'b1
  } dom_t;

  typedef enum logic [1:0] {
    S_L     = 2'd0,
    S_H     = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Width of a down-counter able to hold (largest length - 1); never below 1 bit.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// Loadable down-counter for slot timing: counts down to zero and holds there
// until reloaded. zero flags the last cycle of the current slot.
module tdm_slot_timer #(
  parameter int          W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] tmr_q, tmr_d;

  // Next count: reload on request, otherwise decrement until zero.
  always_comb begin
    tmr_d = tmr_q;
    if (load)              tmr_d = load_val;
    else if (tmr_q != '0)  tmr_d = tmr_q - 1'b1;
  end

  // Counter register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= RST_VAL;
    else        tmr_q <= tmr_d;
  end

  assign zero = (tmr_q == '0);

endmodule

// File: rtl/tdm_domain_arbiter.sv
// Time-division arbiter sharing one resource port between an L and an H
// requester. Slot changes depend only on the timer, never on requests, data
// or res_ready, so H activity cannot shift L timing.
// Build option: define TDM_FLUSH_EN to insert a scrub slot after every H slot.
module tdm_domain_arbiter
  import tdm_pkg::*;
#(
  parameter int DW         = 16,
  parameter int L_SLOT_LEN = 10,
  parameter int H_SLOT_LEN = 10,
  parameter int FLUSH_LEN  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          l_req,
  input  logic [DW-1:0] l_data,
  output logic          l_gnt,
  input  logic          h_req,
  input  logic [DW-1:0] h_data,
  output logic          h_gnt,
  input  logic          res_ready,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          res_dom,
  output logic          cur_dom,
  output logic          scrub
);

  localparam int TW = tmr_width(L_SLOT_LEN, H_SLOT_LEN, FLUSH_LEN);
  localparam logic [TW-1:0] L_RELOAD = TW'(L_SLOT_LEN - 1);
  localparam logic [TW-1:0] H_RELOAD = TW'(H_SLOT_LEN - 1);
`ifdef TDM_FLUSH_EN
  localparam logic [TW-1:0] F_RELOAD = TW'(FLUSH_LEN - 1);
`endif

  state_t        state_q, state_d;
  dom_t          cur_dom_q, cur_dom_d;
  logic          tmr_zero;
  logic [TW-1:0] load_val;

  tdm_slot_timer #(
    .W       (TW),
    .RST_VAL (L_RELOAD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_zero),
    .load_val (load_val),
    .zero     (tmr_zero)
  );

  // Next slot and its reload value, taken only on the last cycle of a slot.
  always_comb begin
    state_d  = state_q;
    load_val = L_RELOAD;
    if (tmr_zero) begin
      case (state_q)
        S_L: begin
          state_d  = S_H;
          load_val = H_RELOAD;
        end
`ifdef TDM_FLUSH_EN
        S_H: begin
          state_d  = S_FLUSH;
          load_val = F_RELOAD;
        end
        S_FLUSH: begin
          state_d  = S_L;
          load_val = L_RELOAD;
        end
`else
        S_H: begin
          state_d  = S_L;
          load_val = L_RELOAD;
        end
`endif
        default: begin
          state_d  = S_L;
          load_val = L_RELOAD;
        end
      endcase
    end
    cur_dom_d = (state_d == S_L) ? DOM_L : DOM_H;
  end

  // Slot state and registered owner label.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_L;
      cur_dom_q <= DOM_L;
    end else begin
      state_q   <= state_d;
      cur_dom_q <= cur_dom_d;
    end
  end

`ifdef TDM_FLUSH_EN
  logic scrub_q, scrub_d;

  // Scrub request is asserted for exactly the flush slot.
  always_comb begin
    scrub_d = (state_d == S_FLUSH);
  end

  // Scrub register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scrub_q <= 1'b0;
    else        scrub_q <= scrub_d;
  end

  assign scrub = scrub_q;
`else
  assign scrub = 1'b0;
`endif

  // NOTE: grants are gated with rst_n because the reset state is S_L; without
  // the gate an asserted l_req would still be granted while reset is held.
  assign l_gnt     = rst_n & (state_q == S_L) & l_req & res_ready;
  assign h_gnt     = rst_n & (state_q == S_H) & h_req & res_ready;
  assign res_valid = l_gnt | h_gnt;
  assign res_data  = l_gnt ? l_data : (h_gnt ? h_data : '0);
  assign res_dom   = res_valid & cur_dom_q;
  assign cur_dom   = cur_dom_q;

endmodule

// File: tb/tb_tdm_domain_arbiter.sv
// Directed bench for tdm_domain_arbiter with default slot lengths (10/10, flush 2).
// Expected values come from the cycle count since reset release.
module tb_tdm_domain_arbiter;

  localparam int DW = 16;
  localparam int LS = 10;
  localparam int HS = 10;
`ifdef TDM_FLUSH_EN
  localparam int FL = 2;
`else
  localparam int FL = 0;
`endif
  localparam int P = LS + HS + FL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          l_req = 1'b0;
  logic [DW-1:0] l_data = '0;
  logic          l_gnt;
  logic          h_req = 1'b0;
  logic [DW-1:0] h_data = '0;
  logic          h_gnt;
  logic          res_ready = 1'b0;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_dom;
  logic          cur_dom;
  logic          scrub;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  tdm_domain_arbiter #(
    .DW         (DW),
    .L_SLOT_LEN (LS),
    .H_SLOT_LEN (HS),
    .FLUSH_LEN  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .l_req     (l_req),
    .l_data    (l_data),
    .l_gnt     (l_gnt),
    .h_req     (h_req),
    .h_data    (h_data),
    .h_gnt     (h_gnt),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_dom   (res_dom),
    .cur_dom   (cur_dom),
    .scrub     (scrub)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Compare every output against the slot schedule for the current cycle.
  task automatic check_cycle(input string ph);
    int   pos;
    logic own_l, own_h, e_l, e_h;
    logic [DW-1:0] e_data;
    pos    = cyc % P;
    own_l  = (pos < LS);
    own_h  = (pos >= LS) && (pos < LS + HS);
    e_l    = own_l & l_req & res_ready;
    e_h    = own_h & h_req & res_ready;
    e_data = e_l ? l_data : (e_h ? h_data : '0);
    check({ph, ".l_gnt"},     32'(l_gnt),     32'(e_l));
    check({ph, ".h_gnt"},     32'(h_gnt),     32'(e_h));
    check({ph, ".res_valid"}, 32'(res_valid), 32'(e_l | e_h));
    check({ph, ".res_data"},  32'(res_data),  32'(e_data));
    check({ph, ".res_dom"},   32'(res_dom),   32'(e_h));
    check({ph, ".cur_dom"},   32'(cur_dom),   32'(!own_l));
    check({ph, ".scrub"},     32'(scrub),     32'(pos >= LS + HS));
  endtask

  task automatic check_all_zero(input string ph);
    check({ph, ".l_gnt"},     32'(l_gnt),     32'd0);
    check({ph, ".h_gnt"},     32'(h_gnt),     32'd0);
    check({ph, ".res_valid"}, 32'(res_valid), 32'd0);
    check({ph, ".res_data"},  32'(res_data),  32'd0);
    check({ph, ".res_dom"},   32'(res_dom),   32'd0);
    check({ph, ".cur_dom"},   32'(cur_dom),   32'd0);
    check({ph, ".scrub"},     32'(scrub),     32'd0);
  endtask

  // Hold reset over two edges with both requests active, then release
  // just after an edge; cycle 0 starts at the release.
  task automatic do_reset();
    rst_n     = 1'b0;
    l_req     = 1'b1;
    h_req     = 1'b1;
    res_ready = 1'b1;
    l_data    = 16'h1234;
    h_data    = 16'hBEEF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // Both requesters always active: exactly one grant following the owner.
    do_reset();
    for (int i = 0; i < 2 * P + 3; i++) begin
      #1;
      check_cycle("both");
      next_cycle();
    end

    // H-only request: no grant during L slot, first grant at cycle 10.
    do_reset();
    l_req = 1'b0;
    for (int i = 0; i < P + 2; i++) begin
      #1;
      check_cycle("h_only");
      if (cyc == LS) begin
        check("h_first_gnt", 32'(h_gnt), 32'd1);
        check("h_first_data", 32'(res_data), 32'hBEEF);
        check("h_first_dom", 32'(res_dom), 32'd1);
      end
      next_cycle();
    end

    // Random H activity must not move L timing.
    do_reset();
    for (int i = 0; i < 2 * P + 5; i++) begin
      h_req  = 1'($urandom);
      h_data = 16'($urandom);
      l_data = 16'($urandom);
      #1;
      check_cycle("rand_h");
      next_cycle();
    end

    // Reset in the middle of the H slot, then res_ready gaps in the L slot.
    do_reset();
    h_req  = 1'b1;
    h_data = 16'hBEEF;
    l_data = 16'h1234;
    while (cyc < 14) begin
      #1;
      check_cycle("pre_rst");
      next_cycle();
    end
    #1;
    check_cycle("at14");
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    check_all_zero("mid_rst_edge");
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < P + LS + 2; i++) begin
      res_ready = !((cyc >= 3 && cyc <= 5) || cyc == 9 || cyc == 12);
      #1;
      check_cycle("post_rst");
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
